adc733_codec_model: RTL



---
 rtl/adc733_pkg.sv | 43 ++++
 rtl/adc733_codec_model_if.sv | 26 ++
 rtl/adc733_sclk_gen.sv | 40 ++++
 rtl/adc733_codec_model.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adc733_pkg.sv
// Shared constants, types and helpers for the adc733 codec-side serial model.
package adc733_pkg;

  localparam int unsigned WORD_LEN = 16;
  localparam int unsigned MODE_BIT = 15;
  localparam int unsigned WR_BIT   = 14;
  localparam int unsigned ADDR_MSB = 10;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned SEQ_W    = 13;

  typedef logic [WORD_LEN-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StEcho,
    StData
  } codec_state_e;

  typedef struct packed {
    logic       mode;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
  } ctrl_t;

  // Bits [13:11] of a control word carry no meaning and are dropped here.
  function automatic ctrl_t decode_ctrl(input word_t w);
    ctrl_t c;
    c.mode = w[MODE_BIT];
    c.wr   = w[WR_BIT];
    c.addr = w[ADDR_MSB:ADDR_LSB];
    c.data = w[DATA_MSB:DATA_LSB];
    return c;
  endfunction

  function automatic word_t sample_word(input logic [CH_W-1:0] ch, input logic [SEQ_W-1:0] seq);
    return {ch, seq};
  endfunction

endpackage

// File: rtl/adc733_codec_model_if.sv
// Serial-port bundle between the adc733 wrapper (master) and the codec model (slave).
interface adc733_codec_model_if;

  logic       SE;
  logic       SCLK;
  logic       SDIFS;
  logic       SDI;
  logic       SDOFS;
  logic       SDO;
  logic       data_mode;
  logic       reg_wr;
  logic [2:0] reg_addr;
  logic [7:0] reg_data;
  logic       rx_err;

  modport master (
    output SE, SDIFS, SDI,
    input  SCLK, SDOFS, SDO, data_mode, reg_wr, reg_addr, reg_data, rx_err
  );

  modport slave (
    input  SE, SDIFS, SDI,
    output SCLK, SDOFS, SDO, data_mode, reg_wr, reg_addr, reg_data, rx_err
  );

endinterface

// File: rtl/adc733_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV clocks while enabled, with one-clk edge strobes.
module adc733_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic se,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            sclk_q;
  logic            wrap;

  assign wrap = se && (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (se) begin
      if (wrap) begin
        cnt_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Strobes mark the clk cycle whose edge flips SCLK.
  assign rise = wrap & ~sclk_q;
  assign fall = wrap & sclk_q;
  assign sclk = sclk_q;

endmodule

// File: rtl/adc733_codec_model.sv
// Codec-side emulation of the adc733 serial port: control-word receive, echo and sample frames.
module adc733_codec_model
  import adc733_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned FRAME_LEN = 256
) (
  input logic                  clk,
  input logic                  rst_l,
  adc733_codec_model_if.slave  bus
);

  localparam int unsigned FrameW   = $clog2(FRAME_LEN);
  localparam int unsigned DataBits = NUM_CH * WORD_LEN;

  logic rise, fall;

  adc733_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk  (clk),
    .rst_l(rst_l),
    .se   (bus.SE),
    .sclk (bus.SCLK),
    .rise (rise),
    .fall (fall)
  );

  // Receive path
  logic [14:0] rx_sh_q;
  logic [3:0]  rx_cnt_q;
  logic        rx_err_q;
  logic        reg_wr_q;
  logic [2:0]  reg_addr_q;
  logic [7:0]  reg_data_q;
  logic        rx_done;
  word_t       rx_word;
  ctrl_t       rx_ctrl;

  assign rx_done = rise && !bus.SDIFS && (rx_cnt_q == 4'd15);
  assign rx_word = {rx_sh_q, bus.SDI};
  assign rx_ctrl = decode_ctrl(rx_word);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_err_q   <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      rx_err_q <= 1'b0;
      reg_wr_q <= 1'b0;
      if (rise) begin
        if (bus.SDIFS) begin
          // A sync mid-word drops the partial word and restarts on this bit.
          rx_err_q <= (rx_cnt_q != 4'd0);
          rx_sh_q  <= {14'd0, bus.SDI};
          rx_cnt_q <= 4'd1;
        end else if (rx_cnt_q != 4'd0) begin
          rx_sh_q  <= {rx_sh_q[13:0], bus.SDI};
          rx_cnt_q <= rx_cnt_q + 4'd1;
        end
      end
      if (rx_done && rx_ctrl.wr) begin
        reg_wr_q   <= 1'b1;
        reg_addr_q <= rx_ctrl.addr;
        reg_data_q <= rx_ctrl.data;
      end
    end
  end

  // Transmit / mode state
  codec_state_e     state_q;
  logic             data_mode_q;
  logic             exit_req_q;
  logic             pend_valid_q;
  word_t            pend_word_q;
  logic [14:0]      tx_sh_q;
  logic [3:0]       tx_cnt_q;
  logic             tx_mode_q;
  logic             sdo_q;
  logic             sdofs_q;
  logic [FrameW-1:0] frame_cnt_q;
  logic [SEQ_W-1:0] seq_q;

  logic      in_burst;
  logic      frame_last;
  logic      burst_last;
  word_t     cur_word;
  logic      load_echo;

  assign in_burst   = 32'(frame_cnt_q) < DataBits;
  assign frame_last = frame_cnt_q == FrameW'(FRAME_LEN - 1);
  assign burst_last = frame_cnt_q == FrameW'(DataBits - 1);
  assign cur_word   = sample_word(CH_W'(frame_cnt_q >> 4), seq_q);

  // An echo starts from idle, or back-to-back when a non-mode-switching echo ends.
  assign load_echo = fall && pend_valid_q &&
                     ((state_q == StIdle) ||
                      ((state_q == StEcho) && (tx_cnt_q == 4'd15) && !tx_mode_q));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StIdle;
      data_mode_q  <= 1'b0;
      exit_req_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      tx_sh_q      <= '0;
      tx_cnt_q     <= '0;
      tx_mode_q    <= 1'b0;
      sdo_q        <= 1'b0;
      sdofs_q      <= 1'b0;
      frame_cnt_q  <= '0;
      seq_q        <= '0;
    end else begin
      if (rx_done) begin
        pend_valid_q <= 1'b1;
        pend_word_q  <= rx_word;
        if ((state_q == StData) && !rx_ctrl.mode) begin
          exit_req_q <= 1'b1;
        end
      end

      if (fall) begin
        unique case (state_q)
          StIdle: begin
            sdo_q   <= 1'b0;
            sdofs_q <= 1'b0;
          end
          StEcho: begin
            sdofs_q <= 1'b0;
            if (tx_cnt_q != 4'd15) begin
              tx_cnt_q <= tx_cnt_q + 4'd1;
              sdo_q    <= tx_sh_q[14];
              tx_sh_q  <= {tx_sh_q[13:0], 1'b0};
            end else if (tx_mode_q) begin
              state_q      <= StData;
              data_mode_q  <= 1'b1;
              pend_valid_q <= 1'b0;
              exit_req_q   <= 1'b0;
              frame_cnt_q  <= '0;
              seq_q        <= '0;
              sdo_q        <= 1'b0;
            end else begin
              state_q <= StIdle;
              sdo_q   <= 1'b0;
            end
          end
          StData: begin
            sdofs_q     <= in_burst && (frame_cnt_q[3:0] == 4'd0);
            sdo_q       <= in_burst && cur_word[~frame_cnt_q[3:0]];
            frame_cnt_q <= frame_last ? '0 : frame_cnt_q + FrameW'(1);
            if (burst_last) begin
              seq_q <= seq_q + SEQ_W'(1);
            end
            if (frame_last && exit_req_q) begin
              state_q     <= StIdle;
              data_mode_q <= 1'b0;
              exit_req_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase

        if (load_echo) begin
          state_q      <= StEcho;
          pend_valid_q <= 1'b0;
          tx_sh_q      <= pend_word_q[14:0];
          tx_mode_q    <= pend_word_q[MODE_BIT];
          tx_cnt_q     <= 4'd0;
          sdo_q        <= pend_word_q[15];
          sdofs_q      <= 1'b1;
        end
      end
    end
  end

  assign bus.SDO       = sdo_q;
  assign bus.SDOFS     = sdofs_q;
  assign bus.data_mode = data_mode_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.rx_err    = rx_err_q;

endmodule
